proc_ctrl_scoreboard: RTL

- Parametrised hazard and writeback tracker for the in-order TinyRV1 pipeline, with a multi-cycle pipelined multiplier.
- Pipeline is F, D, X1..XL, M, W, where L = MUL_LAT.
- Sits in the control unit and replaces hard-wired X/M/W compare logic with a shift-register scoreboard.
- Produces the D-stage stall, per-operand bypass selects, and the W-stage RF write controls.

---
 rtl/proc_sb_pkg.sv | 33 +++
 rtl/proc_sb_byp_lookup.sv | 44 ++++
 rtl/proc_ctrl_scoreboard.sv | 113 +++++++++++
 3 files changed

// File: rtl/proc_sb_pkg.sv
// Shared types and helpers for the TinyRV1 hazard/writeback scoreboard.
// Optional feature macro used by the top: PROC_SB_PERF_CNT_EN.
package proc_sb_pkg;

    // Producer class of the instruction occupying a slot.
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LW  = 2'd1,
        FU_MUL = 2'd2,
        FU_JAL = 2'd3
    } fu_t;

    // The rd field is sized for the largest register file we support
    // (256 registers); narrower addresses are zero-extended on entry.
    localparam int SB_RD_W = 8;

    typedef struct packed {
        logic               val;
        logic               wen;
        logic [SB_RD_W-1:0] rd;
        fu_t                fu;
    } sb_entry_t;

    // First slot index at which a producer's result can be bypassed.
    function automatic int ready_slot(input fu_t fu, input int mul_lat);
        case (fu)
            FU_MUL:  return mul_lat - 1;
            FU_LW:   return mul_lat;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/proc_sb_byp_lookup.sv
// Youngest-match priority search for one source operand over the slot array.
// Returns a stall request when the youngest producer is not yet ready, or the
// bypass select (slot index + 1, 0 = register file) when it is.
module proc_sb_byp_lookup
    import proc_sb_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int AW      = 5,
    localparam int DEPTH  = MUL_LAT + 2,
    localparam int SW     = $clog2(DEPTH + 1)
) (
    input  logic                  en_i,
    input  logic [AW-1:0]         addr_i,
    input  sb_entry_t [DEPTH-1:0] slots_i,
    output logic                  stall_req_o,
    output logic [SW-1:0]         byp_sel_o
);

    logic               found;
    logic [SB_RD_W-1:0] addr_ext;

    assign addr_ext = SB_RD_W'(addr_i);

    // Scan from the youngest slot; the first match decides bypass or stall.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        found       = 1'b0;
        stall_req_o = 1'b0;
        byp_sel_o   = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (!found && en_i && slots_i[s].val && slots_i[s].wen &&
                (slots_i[s].rd != '0) && (slots_i[s].rd == addr_ext)) begin
                found = 1'b1;
                if (s >= ready_slot(slots_i[s].fu, MUL_LAT)) begin
                    byp_sel_o = SW'(s + 1);
                end else begin
                    stall_req_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/proc_ctrl_scoreboard.sv
// Shift-register scoreboard for the in-order TinyRV1 pipeline with an
// L-stage pipelined multiplier: D-stage stall, operand bypass selects and
// W-stage register-file write controls.
// Optional feature macro: PROC_SB_PERF_CNT_EN (stall / bypass counters).
module proc_ctrl_scoreboard
    import proc_sb_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int AW      = $clog2(NREGS),
    parameter int MUL_LAT = 3,
    localparam int DEPTH  = MUL_LAT + 2,
    localparam int SW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_val,
    input  logic          d_squash,
    input  logic          d_rs1_en,
    input  logic [AW-1:0] d_rs1,
    input  logic          d_rs2_en,
    input  logic [AW-1:0] d_rs2,
    input  logic          d_wen,
    input  logic [AW-1:0] d_rd,
    input  logic [1:0]    d_fu,
    output logic          stall_D,
    output logic          issue,
    output logic [SW-1:0] op1_byp_sel,
    output logic [SW-1:0] op2_byp_sel,
    output logic          rf_wen_W,
    output logic [AW-1:0] rf_waddr_W
`ifdef PROC_SB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_byp_cnt
`endif
);

    sb_entry_t [DEPTH-1:0] slots_q, slots_d;
    sb_entry_t             d_entry;
    logic                  rs1_stall_req, rs2_stall_req;
    logic                  d_live;

    assign d_entry = '{val: 1'b1, wen: d_wen, rd: SB_RD_W'(d_rd), fu: fu_t'(d_fu)};

    proc_sb_byp_lookup #(.MUL_LAT(MUL_LAT), .AW(AW)) u_rs1_lookup (
        .en_i        (d_rs1_en),
        .addr_i      (d_rs1),
        .slots_i     (slots_q),
        .stall_req_o (rs1_stall_req),
        .byp_sel_o   (op1_byp_sel)
    );

    proc_sb_byp_lookup #(.MUL_LAT(MUL_LAT), .AW(AW)) u_rs2_lookup (
        .en_i        (d_rs2_en),
        .addr_i      (d_rs2),
        .slots_i     (slots_q),
        .stall_req_o (rs2_stall_req),
        .byp_sel_o   (op2_byp_sel)
    );

    // A squashed D instruction neither stalls nor issues.
    assign d_live  = d_val & ~d_squash;
    assign stall_D = d_live & (rs1_stall_req | rs2_stall_req);
    assign issue   = d_live & ~stall_D;

    assign rf_wen_W   = slots_q[DEPTH-1].val & slots_q[DEPTH-1].wen &
                        (slots_q[DEPTH-1].rd != '0);
    assign rf_waddr_W = rf_wen_W ? AW'(slots_q[DEPTH-1].rd) : '0;

    // Next slot contents: everything moves one stage older every cycle.
    always_comb begin
        slots_d    = '0;
        slots_d[0] = issue ? d_entry : '0;
        for (int i = 1; i < DEPTH; i++) begin
            slots_d[i] = slots_q[i-1];
        end
    end

    // Slot registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the whole slot array is reset (not just val) so no stale
        // rd/fu bits can ever be observed; it is a handful of flops.
        if (!rst) begin
            slots_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all
            // slots shift simultaneously regardless of statement order.
            slots_q <= slots_d;
        end
    end

`ifdef PROC_SB_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_byp_q;
    logic        byp_used;

    assign byp_used = issue & ((op1_byp_sel != '0) | (op2_byp_sel != '0));

    // Saturating event counters for stall cycles and bypassed issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_byp_q   <= '0;
        end else begin
            if (stall_D && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if (byp_used && (perf_byp_q != '1))  perf_byp_q   <= perf_byp_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_byp_cnt   = perf_byp_q;
`endif

endmodule
